// File: rtl/alu_pkg.sv
// Shared opcode, shifter-mode and FSM definitions for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_ROL = 4'd6;
  localparam logic [3:0] OP_SUB = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  localparam logic [2:0] SH_SLL = 3'd0;
  localparam logic [2:0] SH_SRL = 3'd1;
  localparam logic [2:0] SH_SRA = 3'd2;
  localparam logic [2:0] SH_ROL = 3'd3;
  localparam logic [2:0] SH_ROR = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // Non-shift opcodes map to SH_SLL; their shifter output is simply ignored.
  function automatic logic [2:0] shift_mode(input logic [3:0] op);
    case (op)
      OP_SRL:  shift_mode = SH_SRL;
      OP_SRA:  shift_mode = SH_SRA;
      OP_ROL:  shift_mode = SH_ROL;
      OP_ROR:  shift_mode = SH_ROR;
      default: shift_mode = SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit: logical/arithmetic shifts and rotates by 'amount'.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SHW-1:0]   amount,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] result
);

  localparam logic [SHW:0] WBITS = (SHW+1)'(WIDTH);

  logic [SHW:0]       back_amount;
  logic [WIDTH-1:0]   rol_value;
  logic [WIDTH-1:0]   ror_value;

  // A complementary shift of WIDTH yields zero, so amount 0 rotates to value itself.
  assign back_amount = WBITS - {1'b0, amount};
  assign rol_value   = (value << amount) | (value >> back_amount);
  assign ror_value   = (value >> amount) | (value << back_amount);

  always_comb begin
    result = value;
    case (mode)
      SH_SLL:  result = value << amount;
      SH_SRL:  result = value >> amount;
      SH_SRA:  result = $unsigned($signed(value) >>> amount);
      SH_ROL:  result = rol_value;
      SH_ROR:  result = ror_value;
      default: result = value;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU: single-cycle add/logic/shift ops plus an iterative shift-add
// multiplier that reuses the main adder over WIDTH cycles.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sr1,
  input  logic [WIDTH-1:0] sr2,
  input  logic [3:0]       os,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             zeroflag,
  output logic             carry,
  output logic             ovf
);

  state_t           state, state_next;
  logic [WIDTH-1:0] mul_a, mul_b, acc;
  logic [SHW-1:0]   mul_count;
  logic             accept, mul_start, mul_last;

  logic [WIDTH-1:0] add_a, add_b;
  logic             add_cin;
  logic [WIDTH:0]   sum;

  logic [WIDTH-1:0] shift_result, alu_result;
  logic             alu_zero, alu_carry, alu_ovf;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (os == OP_MUL);
  assign mul_last  = (state == MUL) && (mul_count == SHW'(WIDTH-1));

  // The one adder serves add, sub (a + ~b + 1) and each partial-product step of mul.
  always_comb begin
    add_a   = sr1;
    add_b   = sr2;
    add_cin = 1'b0;
    if (state == MUL) begin
      add_a = acc;
      add_b = mul_b[0] ? mul_a : '0;
    end else if (os == OP_SUB) begin
      add_b   = ~sr2;
      add_cin = 1'b1;
    end
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .value  (sr1),
    .amount (sr2[SHW-1:0]),
    .mode   (shift_mode(os)),
    .result (shift_result)
  );

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    alu_zero   = 1'b0;
    case (os)
      OP_ADD, OP_SUB: begin
        alu_result = sum[WIDTH-1:0];
        alu_carry  = sum[WIDTH];
        alu_ovf    = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                     (sum[WIDTH-1] != add_a[WIDTH-1]);
      end
      OP_OR:  alu_result = sr1 | sr2;
      OP_AND: alu_result = sr1 & sr2;
      OP_XOR: alu_result = sr1 ^ sr2;
      OP_NOR: alu_result = ~(sr1 | sr2);
      OP_SLL, OP_ROL, OP_SRL, OP_SRA, OP_ROR: alu_result = shift_result;
      default: alu_result = '0;
    endcase
    // Undefined opcodes report every flag low, including zero.
    if (os < OP_MUL) begin
      alu_zero = (alu_result == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (mul_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are latched at acceptance so the requester may move on immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      mul_count <= '0;
    end else if (mul_start) begin
      mul_a     <= sr1;
      mul_b     <= sr2;
      acc       <= '0;
      mul_count <= '0;
    end else if (state == MUL) begin
      acc       <= sum[WIDTH-1:0];
      mul_a     <= mul_a << 1;
      mul_b     <= mul_b >> 1;
      mul_count <= mul_count + 1'b1;
    end
  end

  // The output register is always free when mul completes, since mul was only
  // accepted while the previous result was leaving.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      rd        <= '0;
      zeroflag  <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else if (mul_last) begin
      out_valid <= 1'b1;
      rd        <= sum[WIDTH-1:0];
      zeroflag  <= (sum[WIDTH-1:0] == '0);
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept && (os != OP_MUL)) begin
      out_valid <= 1'b1;
      rd        <= alu_result;
      zeroflag  <= alu_zero;
      carry     <= alu_carry;
      ovf       <= alu_ovf;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): directed vector table, handshake
// corner sequences and a randomized stream scored against a behavioural model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk, reset;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] sr1, sr2, rd;
  logic [3:0]       os;
  logic             zeroflag, carry, ovf;

  int check_count = 0;
  int pass_count  = 0;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sr1       (sr1),
    .sr2       (sr2),
    .os        (os),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .zeroflag  (zeroflag),
    .carry     (carry),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_rd;
    logic        exp_z;
    logic        exp_c;
    logic        exp_v;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned ua, ub, wide;
    longint sa, sb, s;
    int n;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    n  = int'(b % 32);
    e  = '{r: 32'h0, z: 1'b0, c: 1'b0, v: 1'b0};
    case (op)
      OP_ADD: begin
        wide = ua + ub;
        e.r  = 32'(wide);
        e.c  = (wide > 64'hFFFF_FFFF);
        s    = sa + sb;
        e.v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUB: begin
        e.r = a - b;
        e.c = (a >= b);
        s   = sa - sb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_OR:  e.r = a | b;
      OP_AND: e.r = a & b;
      OP_XOR: e.r = a ^ b;
      OP_NOR: e.r = ~(a | b);
      OP_SLL: e.r = 32'(ua * (64'd1 << n));
      OP_SRL: e.r = 32'(ua / (64'd1 << n));
      OP_SRA: begin
        s   = sa >>> n;
        e.r = 32'(s);
      end
      OP_ROL: begin
        e.r = a;
        repeat (n) e.r = {e.r[30:0], e.r[31]};
      end
      OP_ROR: begin
        e.r = a;
        repeat (n) e.r = {e.r[0], e.r[31:1]};
      end
      OP_MUL: e.r = 32'(ua * ub);
      default: e.r = 32'h0;
    endcase
    e.z = (op <= OP_MUL) && (e.r == 32'h0);
    return e;
  endfunction

  // Issue one op, wait for acceptance, then wait (bounded) for the result.
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int lat);
    int waitc;
    @(negedge clk);
    os        = op;
    sr1       = a;
    sr2       = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!in_ready) check_output("accept_timeout", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sr1      = $urandom;
    sr2      = $urandom;
    os       = 4'($urandom);
    lat      = 1;
    while (!out_valid && lat < WIDTH + 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[19];
    exp_t q[$];
    exp_t e;
    int   lat, low, waitc;
    logic saw_valid;
    logic [3:0] op;
    logic [31:0] a, b;

    vecs[0]  = '{"add_wrap",   OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1};
    vecs[1]  = '{"sub_ovf",    OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1};
    vecs[2]  = '{"sra_neg",    OP_SRA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{"ror_one",    OP_ROR, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{"rol_zero",   OP_ROL, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{"sll_31",     OP_SLL, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{"srl_31",     OP_SRL, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{"or",         OP_OR,  32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{"and",        OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{"xor_self",   OP_XOR, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[10] = '{"nor_zero",   OP_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{"add_ovf",    OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1};
    vecs[12] = '{"sub_equal",  OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1};
    vecs[13] = '{"sub_borrow", OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1};
    vecs[14] = '{"op13",       4'd13,  32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[15] = '{"mul_basic",  OP_MUL, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, 1'b0, 1'b0, 33};
    vecs[16] = '{"mul_max",    OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 33};
    vecs[17] = '{"ror_amt32",  OP_ROR, 32'h8000_0001, 32'h0000_0020, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 1};
    vecs[18] = '{"sra_pos",    OP_SRA, 32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF, 1'b0, 1'b0, 1'b0, 1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    os        = 4'd0;
    sr1       = '0;
    sr2       = '0;

    @(negedge clk);
    @(negedge clk);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_rd", rd, 0);
    check_output("reset_flags", {zeroflag, carry, ovf}, 0);
    check_output("reset_in_ready", in_ready, 1);
    reset = 1'b0;

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check_output({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
      check_output({vecs[i].name, "_zero"}, zeroflag, vecs[i].exp_z);
      check_output({vecs[i].name, "_carry"}, carry, vecs[i].exp_c);
      check_output({vecs[i].name, "_ovf"}, ovf, vecs[i].exp_v);
      check_output({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      consume_result();
    end

    $display("[TB] mul busy window");
    @(negedge clk);
    os        = OP_MUL;
    sr1       = 32'h0001_0001;
    sr2       = 32'h0001_0001;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_output("mul_accept_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sr1      = $urandom;
    sr2      = $urandom;
    low      = 0;
    while (!in_ready && low < WIDTH + 10) begin
      low++;
      @(negedge clk);
    end
    check_output("mul_busy_cycles", low, 32);
    check_output("mul_done_valid", out_valid, 1);
    check_output("mul_done_rd", rd, 32'h0002_0001);
    @(negedge clk);
    check_output("mul_drained_valid", out_valid, 0);
    out_ready = 1'b0;

    $display("[TB] output backpressure");
    @(negedge clk);
    os       = OP_ADD;
    sr1      = 32'd10;
    sr2      = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("bp_first_rd", rd, 32'd30);
    os  = OP_XOR;
    sr1 = 32'h0000_FF00;
    sr2 = 32'h0000_0F0F;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_output("bp_hold_ready", in_ready, 0);
      check_output("bp_hold_rd", rd, 32'd30);
      check_output("bp_hold_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check_output("bp_release_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_output("bp_next_rd", rd, 32'h0000_F00F);
    check_output("bp_next_valid", out_valid, 1);
    @(negedge clk);
    check_output("bp_clear_valid", out_valid, 0);
    out_ready = 1'b0;

    $display("[TB] reset during mul");
    @(negedge clk);
    os        = OP_MUL;
    sr1       = $urandom;
    sr2       = $urandom;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("rst_mul_valid", out_valid, 0);
    check_output("rst_mul_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("rst_release_ready", in_ready, 1);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check_output("rst_no_result", saw_valid, 0);
    apply_stimulus(OP_ADD, 32'h1111_1111, 32'h2222_2222, lat);
    check_output("rst_add_rd", rd, 32'h3333_3333);
    check_output("rst_add_latency", lat, 1);
    consume_result();

    $display("[TB] randomized stream");
    @(negedge clk);
    for (int cyc = 0; cyc < 700; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      op        = 4'($urandom_range(0, 15));
      if (op == OP_MUL && $urandom_range(0, 3) != 0) op = OP_ADD;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 31);
        1:       b = a;
        2:       b = 32'h0;
        default: b = $urandom;
      endcase
      os  = op;
      sr1 = a;
      sr2 = b;
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_output("stream_spurious", out_valid, 0);
        end else begin
          e = q.pop_front();
          check_output("stream_rd", rd, e.r);
          check_output("stream_flags", {zeroflag, carry, ovf}, {e.z, e.c, e.v});
        end
      end
      if (in_valid && in_ready) q.push_back(ref_model(op, a, b));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitc     = 0;
    while (q.size() > 0 && waitc < 100) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        check_output("drain_rd", rd, e.r);
        check_output("drain_flags", {zeroflag, carry, ovf}, {e.z, e.c, e.v});
      end
      @(negedge clk);
      waitc++;
    end
    check_output("stream_drain_empty", q.size(), 0);
    #1;
    check_output("stream_final_valid", out_valid, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
